// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and types for the display scheduler.
//   BLANK_CODE : digit code with every segment off (segments active-low)
//   src_e      : display source; its encoding is driven directly on o_active
//   state_e    : scheduler FSM states
package disp_pkg;

  localparam logic [7:0] BLANK_CODE = 8'hFF;

  typedef enum logic [1:0] {
    SRC_BASE = 2'b00,
    SRC_MSG0 = 2'b01,
    SRC_MSG1 = 2'b10
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHOW0 = 2'b01,
    ST_SHOW1 = 2'b10
  } state_e;

endpackage

// File: rtl/disp_msg_slot.sv
// disp_msg_slot: capture slot for one message requester.
// A request snapshots the message, marks it pending and acks it for one
// cycle. The scheduler clears pending with i_take when it starts showing it.
//   i_clk, i_rst_n : game clock, async active-low reset
//   i_req          : request strobe, sampled every edge it is high
//   i_msg          : 32-bit digits, valid with i_req
//   i_take         : scheduler is consuming this slot on this edge
//   o_pend         : message captured and not yet shown
//   o_buf          : latest captured digits
//   o_ack          : one-cycle acknowledge following a sampled request
module disp_msg_slot
  import disp_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic [31:0] i_msg,
  input  logic        i_take,
  output logic        o_pend,
  output logic [31:0] o_buf,
  output logic        o_ack
);

  logic        r_pend;
  logic [31:0] r_buf;
  logic        r_ack;

  // A request on the same edge as a take wins: the new message stays queued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= 1'b0;
      r_buf  <= '0;
      r_ack  <= 1'b0;
    end else begin
      r_ack <= i_req;
      if (i_req) begin
        r_pend <= 1'b1;
        r_buf  <= i_msg;
      end else if (i_take) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_pend = r_pend;
  assign o_buf  = r_buf;
  assign o_ack  = r_ack;

endmodule

// File: rtl/disp_scheduler.sv
// disp_scheduler: time-shares the four-digit display between live game
// digits and two one-shot messages (req[1] high priority, req[0] low).
// Each message is held for HOLD_TICKS game ticks; msg1 blinks with a
// half-period of BLINK_TICKS.
//   i_clk, i_rst_n     : game clock (50 Hz tick), async active-low reset
//   i_base             : live digits {d3,d2,d1,d0}
//   i_req              : message requests
//   i_msg0, i_msg1     : message digits, valid with their request
//   o_ack              : per-request one-cycle acknowledge
//   o_drop             : pulses when a showing msg0 is preempted
//   o_busy             : a message is showing or pending
//   o_active           : current source (00 base, 01 msg0, 10 msg1)
//   o_disp0..o_disp3   : digits to the ssd driver
//
// state    | meaning
// ST_IDLE  | live base digits shown, waiting for a pending message
// ST_SHOW0 | latched msg0 shown steadily until hold expires or msg1 preempts
// ST_SHOW1 | latched msg1 shown blinking until hold expires
module disp_scheduler
  import disp_pkg::*;
#(
  parameter int HOLD_TICKS  = 50,
  parameter int BLINK_TICKS = 12
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_base,
  input  logic [1:0]  i_req,
  input  logic [31:0] i_msg0,
  input  logic [31:0] i_msg1,
  output logic [1:0]  o_ack,
  output logic        o_drop,
  output logic        o_busy,
  output logic [1:0]  o_active,
  output logic [7:0]  o_disp0,
  output logic [7:0]  o_disp1,
  output logic [7:0]  o_disp2,
  output logic [7:0]  o_disp3
);

  localparam int HW = (HOLD_TICKS  > 1) ? $clog2(HOLD_TICKS)  : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_TICKS - 1);

  state_e      r_state;
  logic [HW-1:0] r_hold;
  logic [BW-1:0] r_blink;
  logic        r_phase;
  logic        r_drop;
  logic [31:0] r_shown;

  state_e      w_nxt_state;
  logic        w_enter;
  logic        w_drop;
  logic [1:0]  w_take;
  logic [1:0]  w_pend;
  logic [31:0] w_buf0;
  logic [31:0] w_buf1;
  src_e        w_src;
  logic [31:0] w_disp;

  disp_msg_slot u_slot0 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (i_req[0]),
    .i_msg   (i_msg0),
    .i_take  (w_take[0]),
    .o_pend  (w_pend[0]),
    .o_buf   (w_buf0),
    .o_ack   (o_ack[0])
  );

  disp_msg_slot u_slot1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (i_req[1]),
    .i_msg   (i_msg1),
    .i_take  (w_take[1]),
    .o_pend  (w_pend[1]),
    .o_buf   (w_buf1),
    .o_ack   (o_ack[1])
  );

  // Next-state selection. Messages chain back-to-back with msg1 first;
  // msg1 arriving mid-msg0 cuts msg0 short (unless msg0 is on its last tick,
  // in which case it simply finished).
  always_comb begin
    w_nxt_state = r_state;
    w_enter     = 1'b0;
    w_drop      = 1'b0;
    unique case (r_state)
      ST_SHOW0: begin
        if (w_pend[1] && (r_hold != '0)) begin
          w_nxt_state = ST_SHOW1;
          w_enter     = 1'b1;
          w_drop      = 1'b1;
        end else if (r_hold == '0) begin
          if (w_pend[1]) begin
            w_nxt_state = ST_SHOW1;
            w_enter     = 1'b1;
          end else if (w_pend[0]) begin
            w_nxt_state = ST_SHOW0;
            w_enter     = 1'b1;
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end
      end
      ST_SHOW1: begin
        if (r_hold == '0) begin
          if (w_pend[1]) begin
            w_nxt_state = ST_SHOW1;
            w_enter     = 1'b1;
          end else if (w_pend[0]) begin
            w_nxt_state = ST_SHOW0;
            w_enter     = 1'b1;
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end
      end
      default: begin
        if (w_pend[1]) begin
          w_nxt_state = ST_SHOW1;
          w_enter     = 1'b1;
        end else if (w_pend[0]) begin
          w_nxt_state = ST_SHOW0;
          w_enter     = 1'b1;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
    endcase
  end

  assign w_take[0] = w_enter && (w_nxt_state == ST_SHOW0);
  assign w_take[1] = w_enter && (w_nxt_state == ST_SHOW1);

  // The shown copy is latched on entry so later requests to the same slot
  // only touch the capture buffer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_blink <= '0;
      r_phase <= 1'b0;
      r_drop  <= 1'b0;
      r_shown <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_drop  <= w_drop;
      if (w_enter) begin
        r_hold  <= HOLD_LOAD;
        r_blink <= BLINK_LOAD;
        r_phase <= 1'b1;
        r_shown <= (w_nxt_state == ST_SHOW1) ? w_buf1 : w_buf0;
      end else if (r_state != ST_IDLE) begin
        if (r_hold != '0) begin
          r_hold <= r_hold - HW'(1);
        end
        if (r_state == ST_SHOW1) begin
          if (r_blink == '0) begin
            r_phase <= ~r_phase;
            r_blink <= BLINK_LOAD;
          end else begin
            r_blink <= r_blink - BW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    w_src  = SRC_BASE;
    w_disp = i_base;
    unique case (r_state)
      ST_SHOW0: begin
        w_src  = SRC_MSG0;
        w_disp = r_shown;
      end
      ST_SHOW1: begin
        w_src  = SRC_MSG1;
        w_disp = r_phase ? r_shown : {4{BLANK_CODE}};
      end
      default: begin
        w_src  = SRC_BASE;
        w_disp = i_base;
      end
    endcase
  end

  assign o_active = w_src;
  assign o_drop   = r_drop;
  assign o_busy   = (r_state != ST_IDLE) || (|w_pend);
  assign o_disp0  = w_disp[7:0];
  assign o_disp1  = w_disp[15:8];
  assign o_disp2  = w_disp[23:16];
  assign o_disp3  = w_disp[31:24];

endmodule

// File: tb/tb_disp_scheduler.sv
module tb_disp_scheduler;

  localparam logic [31:0] B  = 32'h11223344;
  localparam logic [31:0] M0 = 32'h01020304;
  localparam logic [31:0] M1 = 32'hA1A2A3A4;
  localparam logic [31:0] BL = 32'hFFFFFFFF;
  localparam logic [31:0] AA = 32'hAAAAAAAA;
  localparam logic [31:0] BB = 32'hBBBBBBBB;

  logic        clk;
  logic        rst_n;
  logic [31:0] base;
  logic [1:0]  req;
  logic [31:0] msg0;
  logic [31:0] msg1;
  logic [1:0]  ack;
  logic        drop;
  logic        busy;
  logic [1:0]  active;
  logic [7:0]  disp0, disp1, disp2, disp3;

  disp_scheduler #(.HOLD_TICKS(4), .BLINK_TICKS(2)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_base   (base),
    .i_req    (req),
    .i_msg0   (msg0),
    .i_msg1   (msg1),
    .o_ack    (ack),
    .o_drop   (drop),
    .o_busy   (busy),
    .o_active (active),
    .o_disp0  (disp0),
    .o_disp1  (disp1),
    .o_disp2  (disp2),
    .o_disp3  (disp3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int          cyc;
    int          scen;
    logic [1:0]  act;
    logic [31:0] disp;
    logic [1:0]  ack;
    logic        drop;
    logic        busy;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic exp_at(input int cyc, input int scen, input logic [1:0] a,
                        input logic [31:0] d, input logic [1:0] k,
                        input logic dr, input logic bz);
    exp_t e;
    e.cyc = cyc; e.scen = scen; e.act = a; e.disp = d;
    e.ack = k; e.drop = dr; e.busy = bz;
    q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] r, input logic [31:0] m0, input logic [31:0] m1);
    req  = r;
    msg0 = m0;
    msg1 = m1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 32'h0, 32'h0);
  endtask

  // Monitor: outputs sampled mid-cycle, compared against queued expectations.
  exp_t        m_e;
  logic [31:0] m_disp;
  always begin
    @(negedge clk);
    while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
      m_e    = q.pop_front();
      m_disp = {disp3, disp2, disp1, disp0};
      n_checks++;
      if (m_e.cyc != edge_cnt || active !== m_e.act || m_disp !== m_e.disp ||
          ack !== m_e.ack || drop !== m_e.drop || busy !== m_e.busy) begin
        $display("FAIL out_chk scen=%0d cyc=%0d/%0d got act=%b disp=%h ack=%b drop=%b busy=%b want act=%b disp=%h ack=%b drop=%b busy=%b",
                 m_e.scen, m_e.cyc, edge_cnt, active, m_disp, ack, drop, busy,
                 m_e.act, m_e.disp, m_e.ack, m_e.drop, m_e.busy);
      end else begin
        n_pass++;
      end
    end
  end

  int k;

  initial begin
    rst_n = 1'b0;
    base  = B;
    req   = 2'b00;
    msg0  = 32'h0;
    msg1  = 32'h0;

    // Reset state
    @(negedge clk);
    k = edge_cnt + 1;
    exp_at(k,   0, 2'b00, B, 2'b00, 1'b0, 1'b0);
    exp_at(k+1, 0, 2'b00, B, 2'b00, 1'b0, 1'b0);
    exp_at(k+3, 0, 2'b00, B, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Single msg0
    k = edge_cnt + 1;
    exp_at(k, 1, 2'b00, B, 2'b01, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) exp_at(k+i, 1, 2'b01, M0, 2'b00, 1'b0, 1'b1);
    exp_at(k+5, 1, 2'b00, B, 2'b00, 1'b0, 1'b0);
    drive(2'b01, M0, 32'h0);
    idle(7);

    // Simultaneous requests: msg1 (blinking) then msg0
    k = edge_cnt + 1;
    exp_at(k,   2, 2'b00, B,  2'b11, 1'b0, 1'b1);
    exp_at(k+1, 2, 2'b10, M1, 2'b00, 1'b0, 1'b1);
    exp_at(k+2, 2, 2'b10, M1, 2'b00, 1'b0, 1'b1);
    exp_at(k+3, 2, 2'b10, BL, 2'b00, 1'b0, 1'b1);
    exp_at(k+4, 2, 2'b10, BL, 2'b00, 1'b0, 1'b1);
    for (int i = 5; i <= 8; i++) exp_at(k+i, 2, 2'b01, M0, 2'b00, 1'b0, 1'b1);
    exp_at(k+9, 2, 2'b00, B, 2'b00, 1'b0, 1'b0);
    drive(2'b11, M0, M1);
    idle(11);

    // Preemption of msg0 two cycles into its showing
    k = edge_cnt + 1;
    exp_at(k,   3, 2'b00, B,  2'b01, 1'b0, 1'b1);
    exp_at(k+1, 3, 2'b01, M0, 2'b00, 1'b0, 1'b1);
    exp_at(k+2, 3, 2'b01, M0, 2'b10, 1'b0, 1'b1);
    exp_at(k+3, 3, 2'b10, M1, 2'b00, 1'b1, 1'b1);
    exp_at(k+4, 3, 2'b10, M1, 2'b00, 1'b0, 1'b1);
    exp_at(k+5, 3, 2'b10, BL, 2'b00, 1'b0, 1'b1);
    exp_at(k+6, 3, 2'b10, BL, 2'b00, 1'b0, 1'b1);
    exp_at(k+7, 3, 2'b00, B,  2'b00, 1'b0, 1'b0);
    exp_at(k+8, 3, 2'b00, B,  2'b00, 1'b0, 1'b0);
    drive(2'b01, M0, 32'h0);
    drive(2'b00, 32'h0, 32'h0);
    drive(2'b10, 32'h0, M1);
    idle(9);

    // Overwrite of an unshown msg0 while msg1 is showing
    k = edge_cnt + 1;
    exp_at(k,   4, 2'b00, B,  2'b10, 1'b0, 1'b1);
    exp_at(k+1, 4, 2'b10, M1, 2'b01, 1'b0, 1'b1);
    exp_at(k+2, 4, 2'b10, M1, 2'b00, 1'b0, 1'b1);
    exp_at(k+3, 4, 2'b10, BL, 2'b01, 1'b0, 1'b1);
    exp_at(k+4, 4, 2'b10, BL, 2'b00, 1'b0, 1'b1);
    for (int i = 5; i <= 8; i++) exp_at(k+i, 4, 2'b01, BB, 2'b00, 1'b0, 1'b1);
    exp_at(k+9, 4, 2'b00, B, 2'b00, 1'b0, 1'b0);
    drive(2'b10, 32'h0, M1);
    drive(2'b01, AA, 32'h0);
    drive(2'b00, 32'h0, 32'h0);
    drive(2'b01, BB, 32'h0);
    idle(9);

    // Reset asserted mid-SHOW1 with msg0 also pending
    k = edge_cnt + 1;
    exp_at(k,   5, 2'b00, B,  2'b11, 1'b0, 1'b1);
    exp_at(k+1, 5, 2'b10, M1, 2'b00, 1'b0, 1'b1);
    exp_at(k+2, 5, 2'b00, B,  2'b00, 1'b0, 1'b0);
    exp_at(k+3, 5, 2'b00, B,  2'b00, 1'b0, 1'b0);
    exp_at(k+4, 5, 2'b00, B,  2'b00, 1'b0, 1'b0);
    exp_at(k+6, 5, 2'b00, B,  2'b00, 1'b0, 1'b0);
    drive(2'b11, M0, M1);
    drive(2'b00, 32'h0, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);

    for (int i = 0; i < 30 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
